// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares a single multi-cycle ALU among NREQ requesters,
// filtering illegal opcodes and bounding the wait for ALU completion.
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*4-1:0]       req_cmd,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_error,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [3:0]              alu_cmd,
    input  logic                    alu_ready,
    input  logic                    alu_valid,
    input  logic [WIDTH-1:0]        alu_result,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MAX = 4'b1000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [3:0]        alu_cmd_q, alu_cmd_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_error_q, rsp_error_d;

    logic [IW-1:0]     winner, cand;
    logic              grant;
    logic [WIDTH-1:0]  win_a, win_b;
    logic [3:0]        win_cmd;

    // Rotating priority: scanning from farthest to nearest lets the nearest
    // valid requester after last_grant overwrite the others.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        winner = '0;
        cand   = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IW'((int'(last_grant_q) + off) % NREQ);
            if (req_valid[cand]) winner = cand;
        end
    end

    // Gated by reset so no acceptance is signalled while the block is held in reset.
    assign grant   = reset && (state_q == IDLE) && alu_ready && (|req_valid);
    assign win_a   = req_a[int'(winner)*WIDTH +: WIDTH];
    assign win_b   = req_b[int'(winner)*WIDTH +: WIDTH];
    assign win_cmd = req_cmd[int'(winner)*4 +: 4];

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + 1'b1;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cmd_d    = CMD_NOP;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = winner;
                    if (win_cmd != CMD_NOP && win_cmd <= CMD_MAX) begin
                        alu_a_d   = win_a;
                        alu_b_d   = win_b;
                        alu_cmd_d = win_cmd;
                        cnt_d     = '0;
                        state_d   = ISSUE;
                    end else begin
                        rsp_valid_d[winner] = 1'b1;
                        rsp_result_d        = '0;
                        rsp_error_d         = 1'b1;
                        state_d             = RESP;
                    end
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY, WAIT_DONE: begin
                // Completion is tested first so it beats a timeout in the same cycle.
                if (state_q == WAIT_DONE && alu_ready && alu_valid) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_result_d         = alu_result;
                    state_d              = RESP;
                end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_result_d         = '0;
                    rsp_error_d          = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    // alu_valid is sticky, so a falling alu_ready is the only proof of acceptance.
                    if (state_q == WAIT_BUSY && !alu_ready) state_d = WAIT_DONE;
                end
            end
            RESP: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cmd_q    <= CMD_NOP;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cmd_q    <= alu_cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cmd    = alu_cmd_q;
    assign grant_id   = grant ? winner : owner_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one ALU instance among NREQ requesters.
- Accepts one operation per requester over a valid/ready channel and issues it to the ALU using the ALU's ready/valid protocol.
- Waits for the ALU result, then returns it to the owning requester with a one-cycle response pulse.
- Also filters illegal opcodes and enforces a completion timeout so a hung multiply/divide cannot lock the ALU.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width; must match the ALU.
- TIMEOUT, 64, maximum cycles spent waiting for ALU completion before an error response.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
- req_cmd  input  NREQ*4  ALU opcode, packed [i*4 +: 4].
- req_ready  output  NREQ  one-hot; high for one cycle when requester i's operation is accepted.
- rsp_valid  output  NREQ  one-hot; high for one cycle when the response for requester i is presented.
- rsp_result  output  WIDTH  result, qualified by rsp_valid.
- rsp_error  output  1  qualified by rsp_valid: 1 = illegal opcode or timeout.
- alu_a, alu_b  output  WIDTH  operands to the ALU.
- alu_cmd  output  4  opcode to the ALU; NOP (0000) whenever not in ISSUE.
- alu_ready  input  1  ALU ready to take input.
- alu_valid  input  1  ALU result valid.
- alu_result  input  WIDTH  ALU result.
- grant_id  output  clog2(NREQ)  index of the current or last owner.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; req_ready, rsp_valid, rsp_error and busy go to 0.
  - rsp_result goes to 0; alu_cmd goes to NOP; alu_a and alu_b go to 0.
  - last_grant goes to NREQ-1, so requester 0 has first priority; grant_id goes to 0; the timeout counter goes to 0.
  - Reset mid-operation abandons the operation silently: no response is issued.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE, grant:
  - Grants when any req_valid is high and alu_ready=1.
  - Winner is the first requester with req_valid high, searching from last_grant+1 with wrap-around.
  - In that cycle: req_ready[winner]=1; latch a, b, cmd and the owner index; grant_id=winner.
  - Legal cmd (0001..1000): go to ISSUE.
  - Illegal cmd (0000 or >1000): go to RESP with rsp_error=1 and result 0; the ALU is not touched.
- IDLE, hold: with alu_ready=0 there is no grant and no req_ready, even if requests are pending.
- ISSUE (exactly 1 cycle):
  - Drive alu_a, alu_b, alu_cmd from the latches.
  - Go to WAIT_BUSY and return alu_cmd to NOP.
- WAIT_BUSY:
  - Exit when alu_ready=0, meaning the ALU has taken the command; go to WAIT_DONE.
  - This stage is required because the ALU's valid is sticky from earlier operations.
- WAIT_DONE: when alu_ready=1 and alu_valid=1, capture alu_result and go to RESP.
- Timeout counter:
  - Cleared on entry to ISSUE; increments every cycle spent in WAIT_BUSY or WAIT_DONE.
  - When it reaches TIMEOUT-1 without completion, go to RESP with rsp_error=1 and result 0.
- RESP (1 cycle):
  - rsp_valid[owner]=1 with rsp_result and rsp_error.
  - Update last_grant to the owner; go to IDLE.
- No back-pressure on responses: requesters must sample during the rsp_valid cycle.
- Requester rules:
  - A requester must hold req_valid and its operands stable until it sees req_ready.
  - A requester dropping req_valid before grant is legal; that request is simply never granted.
- Throughput and latency:
  - A new grant is possible in the cycle after RESP.
  - Minimum latency from grant to rsp_valid is 4 cycles (grant, ISSUE, WAIT_BUSY, WAIT_DONE), plus ALU busy time.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0.
- Simultaneous events:
  - A request arriving during RESP is not granted until the next IDLE cycle.
  - Timeout and completion in the same cycle: completion wins and the response has no error.

Test Plan:
- Single request: req0 issues ADD, a=5, b=7 -> req_ready[0] pulses once; alu_cmd=0001 for exactly one cycle; rsp_valid[0]=1 with rsp_result=12 and rsp_error=0.
- Round-robin: all four requesters hold SUB with a=10+i, b=1 -> grant order 0,1,2,3,0; each rsp_result=9+i on its own rsp_valid bit only.
- Illegal opcode: req2 issues cmd=1111 -> req_ready[2] pulses, then rsp_valid[2] with rsp_error=1 and rsp_result=0; alu_cmd stays 0000 throughout.
- Timeout: ALU model holds alu_ready=0 indefinitely after the command -> rsp_error=1 exactly TIMEOUT cycles after ISSUE; the arbiter returns to IDLE and serves the next request normally.
- ALU not ready: alu_ready=0 while req1 is valid -> no req_ready; grant occurs in the first cycle alu_ready=1; MUL a=6, b=7 -> rsp_result=42.
- Reset mid-operation: assert reset low during WAIT_DONE -> all outputs clear immediately with no rsp_valid; after release, req1 (if pending) is granted again and req0 has priority over it.
